// File: rtl/uart_pkg.sv
// Shared UART types and constants.
//   rx_state_e     : receiver FSM state encoding
//   UART_DATA_BITS : data bits per frame
//   UART_MIN_CPB   : smallest usable clks_per_bit divisor
//   UART_CNT_W     : width of bit-timing counters and divisors
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_MIN_CPB   = 2;
  localparam int unsigned UART_CNT_W     = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// N-flop synchronizer for asynchronous pin inputs; flops reset to 1
// so an idle-high line does not produce a spurious low after reset.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   d_i    : asynchronous input
//   q_o    : synchronized output, STAGES cycles of latency
module uart_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift chain; d_i enters at bit 0, q_o taken from the last stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '1;
    else         sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, mid-bit sampling with a runtime divisor.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   rx_en_i        : enable; low aborts any frame and disarms start detect
//   rx_i           : asynchronous serial line, idles high
//   clks_per_bit   : clk_i cycles per bit, latched at start detect (min 2)
//   rx_data_o      : last good byte
//   rx_done_o      : one-cycle pulse when rx_data_o is written
//   frame_err_o    : one-cycle pulse when the stop bit is sampled low
//   busy_o         : high whenever the FSM is outside IDLE
// Optional macro UART_RX_PARITY_EN adds a parity bit before the stop bit,
// input parity_odd_i (1 = odd) and pulse output parity_err_o.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rx_en_i,
  input  logic        rx_i,
  input  logic [15:0] clks_per_bit,
`ifdef UART_RX_PARITY_EN
  input  logic        parity_odd_i,
  output logic        parity_err_o,
`endif
  output logic [7:0]  rx_data_o,
  output logic        rx_done_o,
  output logic        frame_err_o,
  output logic        busy_o
);

  rx_state_e                  state_q, state_d;
  logic [UART_CNT_W-1:0]      cnt_q, cnt_d;
  logic [UART_CNT_W-1:0]      cpb_q, cpb_d;
  logic [2:0]                 idx_q, idx_d;
  logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
  logic [UART_DATA_BITS-1:0]  data_d;
  logic                       done_d, ferr_d;
  logic                       rx_s;
  logic                       par_ok;
  logic [UART_CNT_W-1:0]      cpb_m1, half_m1, cpb_in;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rx_i),
    .q_o    (rx_s)
  );

  // Compares against cpb-1 so the counter never needs to reach cpb.
  assign cpb_m1  = cpb_q - UART_CNT_W'(1);
  assign half_m1 = (cpb_q >> 1) - UART_CNT_W'(1);
  assign cpb_in  = (clks_per_bit < UART_CNT_W'(UART_MIN_CPB)) ?
                   UART_CNT_W'(UART_MIN_CPB) : clks_per_bit;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, perr_d;
  // Data XOR parity bit must equal 1 for odd parity, 0 for even.
  assign par_ok = ((^shift_q) ^ par_q) == parity_odd_i;
`else
  assign par_ok = 1'b1;
`endif

  // State register and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cpb_q       <= UART_CNT_W'(UART_MIN_CPB);
      idx_q       <= '0;
      shift_q     <= '0;
      rx_data_o   <= '0;
      rx_done_o   <= 1'b0;
      frame_err_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cpb_q       <= cpb_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_data_o   <= data_d;
      rx_done_o   <= done_d;
      frame_err_o <= ferr_d;
      busy_o      <= (state_d != IDLE);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_q        <= 1'b0;
      parity_err_o <= 1'b0;
    end else begin
      par_q        <= par_d;
      parity_err_o <= perr_d;
    end
  end
`endif

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cpb_d   = cpb_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = rx_data_o;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    if (!rx_en_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          idx_d = '0;
          if (!rx_s) begin
            cpb_d   = cpb_in;
            state_d = START;
          end
        end
        START: begin
          if (cnt_q == half_m1) begin
            cnt_d   = '0;
            // A start bit gone high by mid-bit is treated as a glitch.
            state_d = rx_s ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + UART_CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_q == cpb_m1) begin
            cnt_d          = '0;
            shift_d[idx_q] = rx_s;
            idx_d          = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            cnt_d = cnt_q + UART_CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == cpb_m1) begin
            cnt_d   = '0;
            par_d   = rx_s;
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + UART_CNT_W'(1);
          end
        end
`endif
        STOP: begin
          if (cnt_q == cpb_m1) begin
            cnt_d   = '0;
            state_d = WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
            perr_d  = !par_ok;
`endif
            if (!rx_s) begin
              ferr_d = 1'b1;
            end else if (par_ok) begin
              data_d = shift_q;
              done_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + UART_CNT_W'(1);
          end
        end
        // Holding here keeps a break (line stuck low) from re-arming.
        WAIT_IDLE: begin
          cnt_d = '0;
          if (rx_s) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus tasks push expected end-of-frame
// events (kind, byte, strobe cycle); a negedge monitor pops and compares.
module tb_uart_rx;

  localparam int K_DONE = 0;
  localparam int K_FERR = 1;
  localparam int K_PERR = 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif

  typedef struct {
    int          kind;
    logic [7:0]  data;
    int unsigned cyc;
  } ev_t;

  logic        clk;
  logic        rst_n;
  logic        rx_en;
  logic        rx;
  logic [15:0] cpb;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        frame_err;
  logic        busy;
`ifdef UART_RX_PARITY_EN
  logic        parity_odd;
  logic        parity_err;
`endif

  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic [7:0]  exp_data = 8'h00;
  ev_t         sb[$];

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rx_en_i      (rx_en),
    .rx_i         (rx),
    .clks_per_bit (cpb),
`ifdef UART_RX_PARITY_EN
    .parity_odd_i (parity_odd),
    .parity_err_o (parity_err),
`endif
    .rx_data_o    (rx_data),
    .rx_done_o    (rx_done),
    .frame_err_o  (frame_err),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               nm, act, act, exp, exp, cyc);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame starting now (caller is at posedge+1). abort_bit<8
  // asserts reset halfway through that data bit and abandons the frame.
  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input logic par_flip, input int abort_bit);
    ev_t e;
    int  c;
    c = int'(cpb);
    rx = 1'b0;
    if (abort_bit > 7) begin
      e.cyc  = cyc + 3 + (c >> 1) + NBITS * c;
      e.data = exp_data;
      if (!stop_b) e.kind = K_FERR;
      else if (par_flip) e.kind = K_PERR;
      else begin
        e.kind   = K_DONE;
        e.data   = d;
        exp_data = d;
      end
      sb.push_back(e);
    end
    hold(c);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == abort_bit) begin
        hold(c / 2);
        rst_n = 1'b0;
        #1;
        exp_data = 8'h00;
        chk("rst_data", int'(rx_data), 0);
        chk("rst_done", int'(rx_done), 0);
        chk("rst_ferr", int'(frame_err), 0);
        chk("rst_busy", int'(busy), 0);
        rx = 1'b1;
        hold(3);
        rst_n = 1'b1;
        hold(2 * c);
        return;
      end
      hold(c);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ parity_odd ^ par_flip;
    hold(c);
`endif
    rx = stop_b;
    hold(c);
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  ev_t e_m;
  int  k_m;
  logic any_m;
  always @(negedge clk) begin
    if (rst_n) begin
      any_m = rx_done | frame_err;
      k_m   = rx_done ? K_DONE : K_FERR;
`ifdef UART_RX_PARITY_EN
      if (parity_err) begin
        any_m = 1'b1;
        if (!frame_err) k_m = K_PERR;
        chk("perr_vs_done", int'(rx_done), 0);
      end
`endif
      if (any_m) begin
        chk("done_ferr_excl", int'(rx_done & frame_err), 0);
        if (sb.size() == 0) begin
          chk("unexpected_strobe", k_m, -1);
        end else begin
          e_m = sb.pop_front();
          chk("ev_kind", k_m, e_m.kind);
          chk("ev_data", int'(rx_data), int'(e_m.data));
          chk("ev_cycle", int'(cyc), int'(e_m.cyc));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    rx_en = 1'b1;
    rx    = 1'b1;
    cpb   = 16'd16;
`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
`endif
    hold(4);
    rst_n = 1'b1;
    hold(3);
    chk("reset_data", int'(rx_data), 0);
    chk("reset_done", int'(rx_done), 0);
    chk("reset_ferr", int'(frame_err), 0);
    chk("reset_busy", int'(busy), 0);

    // Good byte at cpb=16.
    send_frame(8'hA5, 1'b1, 1'b0, 99);
    hold(20);

    // Short low pulse is rejected as a glitch.
    rx = 1'b0;
    hold(4);
    chk("glitch_busy_hi", int'(busy), 1);
    rx = 1'b1;
    hold(30);
    chk("glitch_busy_lo", int'(busy), 0);
    chk("glitch_data", int'(rx_data), 'hA5);

    // Good byte, then framing error followed by a held-low line.
    send_frame(8'h11, 1'b1, 1'b0, 99);
    send_frame(8'h3C, 1'b0, 1'b0, 99);
    hold(40);
    chk("break_busy", int'(busy), 1);
    rx = 1'b1;
    hold(5);
    chk("break_idle", int'(busy), 0);
    chk("break_data", int'(rx_data), 'h11);

    // Back-to-back frames with no idle gap at cpb=10.
    cpb = 16'd10;
    send_frame(8'h00, 1'b1, 1'b0, 99);
    send_frame(8'hFF, 1'b1, 1'b0, 99);
    rx = 1'b1;
    hold(20);

    // Reset in data bit 3, then a clean frame.
    send_frame(8'hC3, 1'b1, 1'b0, 3);
    chk("post_rst_data", int'(rx_data), 0);
    send_frame(8'h5A, 1'b1, 1'b0, 99);
    hold(20);

`ifdef UART_RX_PARITY_EN
    // Even parity: 8'h07 needs parity bit 1; bit 0 is an error.
    send_frame(8'h07, 1'b1, 1'b1, 99);
    hold(10);
    send_frame(8'h07, 1'b1, 1'b0, 99);
    hold(10);
`endif

    hold(50);
    chk("scoreboard_empty", sb.size(), 0);
    chk("final_data", int'(rx_data), int'(exp_data));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver, the receive half of the UART peripheral: 1 start bit, 8 data bits LSB first, 1 stop bit (8N1). It samples the `rx_i` pin at mid-bit using a runtime-programmable `clks_per_bit` divisor. Each received byte is presented on `rx_data_o` with a one-cycle `rx_done_o` strobe. Framing and glitch handling are built in. It sits beside the transmitter under the UART register-interface wrapper.

## Interface
- `SYNC_STAGES`, default 2: flop stages in the `rx_i` synchronizer; minimum 2.
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `rx_en_i`  in  1  receive enable; low disarms start detection and aborts a frame in progress.
- `rx_i`  in  1  asynchronous serial line; idles high.
- `clks_per_bit`  in  16  clk_i cycles per bit (f_clk / baud).
- `rx_data_o`  out  8  last good byte; holds until the next good byte.
- `rx_done_o`  out  1  one-cycle pulse when a good byte is written to `rx_data_o`.
- `frame_err_o`  out  1  one-cycle pulse when the stop bit is sampled low.
- `busy_o`  out  1  high in any state other than IDLE.

## Operation
- `rx_i` passes through a `SYNC_STAGES`-flop synchronizer whose flops reset to 1. All decisions below use the synchronized value `rx_s`.
- At start detect, `clks_per_bit` is latched into an internal register `cpb`. Values below 2 are forced to 2. A change mid-frame has no effect.
- **IDLE**
  - Counter = 0, index = 0.
  - If `rx_en_i` and `rx_s`==0 -> START.
- **START**
  - Count up to `cpb>>1` - 1.
  - At the half-bit point: if `rx_s`==0 -> DATA with counter cleared; otherwise this is a glitch -> IDLE, with no strobe.
- **DATA**
  - Count `cpb` cycles, then sample `rx_s` into shift-register bit [index] and clear the counter.
  - Index 0..7; after index 7 -> STOP.
- **STOP**
  - Count `cpb` cycles, then sample `rx_s`.
  - If 1: `rx_data_o` <= shift register and pulse `rx_done_o`.
  - If 0: pulse `frame_err_o`; `rx_data_o` unchanged.
  - Either way -> WAIT_IDLE.
- **WAIT_IDLE**
  - Stay until `rx_s`==1, then -> IDLE.
  - This prevents a break condition (line held low) from retriggering reception.
- `rx_en_i` low in any state -> IDLE next cycle, with no strobes.
- The counter is 16-bit and never wraps, because the compare is against `cpb` - 1.
- Unused state encodings -> IDLE.

## Timing
- Reset values: `rx_data_o`=8'h00, `rx_done_o`=0, `frame_err_o`=0, `busy_o`=0, state IDLE, all counters 0.
- Synchronizer latency is `SYNC_STAGES` cycles from a `rx_i` edge to `rx_s`.
- Let cycle 0 be the cycle in which IDLE sees `rx_s`==0. Sample points then fall at:
  - start-bit check: cycle `cpb>>1`;
  - data bit k: cycle `(cpb>>1)` + `(k+1)*cpb`;
  - stop bit: cycle `(cpb>>1)` + `9*cpb`.
- `rx_done_o` / `frame_err_o` are asserted in the cycle after the stop sample, for exactly 1 cycle. `rx_data_o` updates in that same cycle.
- `rx_done_o` and `frame_err_o` are never high together.
- Back-to-back frames: a start bit arriving immediately after the stop bit is accepted. The stop sample at mid-bit leaves half a bit of margin.

## Configuration
- Macro `UART_RX_PARITY_EN`.
- **Defined:**
  - Adds a PARITY state between DATA and STOP, which samples one extra bit after `cpb` cycles.
  - Adds input `parity_odd_i` (1 = odd parity, 0 = even) and output `parity_err_o`.
  - `parity_err_o` is a one-cycle pulse coincident with the end-of-frame strobe when received parity mismatches; it resets to 0.
  - When `parity_err_o` fires, `rx_data_o` is not updated and `rx_done_o` does not pulse.
  - The stop sample moves to `(cpb>>1)` + `10*cpb`.
- **Undefined:** no parity state and no parity ports; timing exactly as above.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [2:0] rx_state_e` (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE);
  - localparam `UART_DATA_BITS` = 8;
  - localparam `UART_MIN_CPB` = 2.
- Sub-module `uart_sync`: parameterized N-flop synchronizer with reset value 1, reusable by other pin inputs.

## Test plan
- `cpb`=16, send 8'hA5 -> `rx_data_o`=8'hA5. `rx_done_o` high for 1 cycle, 8+144+1 cycles after IDLE sees low. `frame_err_o` stays 0.
- `cpb`=16, `rx_i` low for 4 cycles then high -> no strobes, `busy_o` returns to 0, `rx_data_o` unchanged.
- After a good 8'h11, send 8'h3C with stop bit 0 -> `frame_err_o` pulses, `rx_data_o` stays 8'h11. With the line then held low 40 cycles, no new frame starts until `rx_i` returns high.
- `cpb`=10, frames 8'h00 and 8'hFF back-to-back with no idle gap -> two `rx_done_o` pulses, values 8'h00 then 8'hFF.
- Assert `rst_ni`=0 during data bit 3, then release -> all outputs 0 immediately. A following frame 8'h5A is received correctly.
- With `UART_RX_PARITY_EN`, even parity, send 8'h07 with parity bit 0 -> `parity_err_o` pulses, no `rx_done_o`. With parity bit 1 -> `rx_done_o`, `rx_data_o`=8'h07.
